// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_pkg
// Description : Shared types for the register-file write-port arbiter:
//               register index, write-back request record and arbiter
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int unsigned c_DATA_W = 64;
    localparam int unsigned c_REG_W  = 5;

    typedef logic [c_DATA_W-1:0] data_t;
    typedef logic [c_REG_W-1:0]  reg_idx_t;

    typedef struct packed {
        reg_idx_t rd;
        data_t    data;
    } wb_req_t;

    typedef enum logic [0:0] {
        WB_ARB_NORMAL = 1'b0,
        WB_ARB_DRAIN  = 1'b1
    } wb_arb_state_enum;

endpackage : wb_port_arbiter_pkg
`default_nettype wire

// File: rtl/wb_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_req_fifo
// Description : In-order FIFO of write-back requests for results returning
//               from the long-latency unit.
// Revision    : 1.0 - initial release
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_push, i_req - enqueue one request (caller ensures !o_full)
//               i_pop         - dequeue head (caller ensures !o_empty)
//               o_head        - oldest request
//               o_full, o_empty, o_count - occupancy
// ============================================================================
module wb_req_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  wb_req_t                  i_req,
    input  logic                     i_pop,
    output wb_req_t                  o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    wb_req_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    // Storage carries no reset: occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_req;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule : wb_req_fifo
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between the in-order
//               WB stage and a buffered long-latency result stream. The pipe
//               has priority; starvation, a full buffer or a same-rd (WAW)
//               conflict forces the buffer to drain first.
// Revision    : 1.0 - initial release
// Ports       : clk, rst                     - clock, sync active-high reset
//               pipe_valid/rd/data, pipe_stall - WB stage request / hold
//               ext_valid/rd/data, ext_ready  - long-latency result stream
//               rf_we/rf_rd/rf_wdata          - registered write port
//               busy                          - buffer non-empty or draining
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [63:0] pipe_data,
    output logic        pipe_stall,
    input  logic        ext_valid,
    output logic        ext_ready,
    input  logic [4:0]  ext_rd,
    input  logic [63:0] ext_data,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [63:0] rf_wdata,
    output logic        busy
);

    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_ONE_CNT  = c_CNT_W'(1);
    localparam logic [c_STV_W-1:0] c_STV_MAX  = c_STV_W'(STARVE_LIMIT);

    wb_arb_state_enum      r_state;
    wb_arb_state_enum      w_state_nxt;
    logic [c_STV_W-1:0]    r_starve;
    logic [c_STV_W-1:0]    w_starve_nxt;

    wb_req_t               w_ext_req;
    wb_req_t               w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [c_CNT_W-1:0]    w_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_waw;
    logic                  w_pipe_grant;
    logic                  w_fifo_grant;
    logic                  w_pop_empties;

    logic                  r_rf_we;
    logic [4:0]            r_rf_rd;
    logic [63:0]           r_rf_wdata;

    assign w_ext_req = {ext_rd, ext_data};
    assign w_push    = ext_valid && !w_full;
    assign w_pop     = w_fifo_grant;

    wb_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_req   (w_ext_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A pipe write to the same rd as a buffered older result would be
    // overwritten out of order, so the head goes first while the pipe holds.
    assign w_waw = pipe_valid && !w_empty && (pipe_rd == w_head.rd) && (pipe_rd != '0);

    // A pop that leaves the buffer empty ends any drain.
    assign w_pop_empties = w_pop && !w_push && (w_count == c_ONE_CNT);

    always_comb begin
        w_pipe_grant = 1'b0;
        w_fifo_grant = 1'b0;
        w_state_nxt  = r_state;
        case (r_state)
            WB_ARB_DRAIN: begin
                w_fifo_grant = !w_empty;
                if (w_pop_empties) begin
                    w_state_nxt = WB_ARB_NORMAL;
                end
            end
            default: begin
                w_pipe_grant = pipe_valid && !w_waw;
                w_fifo_grant = !w_empty && !w_pipe_grant;
                // When this cycle's pop already empties the buffer there is
                // nothing left to drain.
                if (!w_pop_empties &&
                    (w_full || (r_starve >= c_STV_MAX) || w_waw)) begin
                    w_state_nxt = WB_ARB_DRAIN;
                end
            end
        endcase
    end

    always_comb begin
        w_starve_nxt = r_starve;
        if (w_pop || w_empty) begin
            w_starve_nxt = '0;
        end else if (r_starve < c_STV_MAX) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= WB_ARB_NORMAL;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // x0 requests are consumed without a write; address/data hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= 1'b0;
            if (w_pipe_grant) begin
                if (pipe_rd != '0) begin
                    r_rf_we    <= 1'b1;
                    r_rf_rd    <= pipe_rd;
                    r_rf_wdata <= pipe_data;
                end
            end else if (w_fifo_grant) begin
                if (w_head.rd != '0) begin
                    r_rf_we    <= 1'b1;
                    r_rf_rd    <= w_head.rd;
                    r_rf_wdata <= w_head.data;
                end
            end
        end
    end

    assign rf_we      = r_rf_we;
    assign rf_rd      = r_rf_rd;
    assign rf_wdata   = r_rf_wdata;
    assign pipe_stall = pipe_valid && !w_pipe_grant;
    assign ext_ready  = !w_full;
    assign busy       = !w_empty || (r_state == WB_ARB_DRAIN);

endmodule : wb_port_arbiter
`default_nettype wire
